// File: rtl/pqsdn_cam_pipe.sv
// ---------------------------------------------------------------------------
// PqsdnCamPipe -- pipelined content-addressable lookup table.
//
// Stores up to 2**ADDR_W keys, each with a valid bit and, in ternary builds,
// a per-entry care mask. A lookup key is compared against every entry in
// parallel. The answer is the lowest matching index plus hit and multi-hit
// flags, and it appears two clock edges after the request is sampled.
//
// Parameters
//   DATA_W   key / entry width
//   ADDR_W   entry index width, depth = 2**ADDR_W
//   TERNARY  1 = per-entry care mask stored, 0 = exact match (mask ignored)
//
// Ports
//   clk          clock, all state on rising edge
//   rst_n        synchronous active-low reset
//   wr_en_i      write-port strobe
//   wr_vld_i     1 = install entry, 0 = invalidate entry
//   wr_addr_i    target entry index
//   wr_data_i    entry key
//   wr_mask_i    care mask (1 = bit compared), ternary builds only
//   lk_req_i     lookup request, one per cycle, no backpressure
//   lk_key_i     lookup key
//   rsp_vld_o    one-cycle result pulse per request
//   rsp_hit_o    at least one valid entry matched
//   rsp_addr_o   lowest matching index, 0 on miss
//   rsp_multi_o  two or more valid entries matched
//   occ_o        number of valid entries
//   full_o       every entry valid
//   empty_o      no entry valid
// ---------------------------------------------------------------------------
module pqsdn_cam_pipe #(
  parameter int DATA_W  = 64,
  parameter int ADDR_W  = 6,
  parameter int TERNARY = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en_i,
  input  logic              wr_vld_i,
  input  logic [ADDR_W-1:0] wr_addr_i,
  input  logic [DATA_W-1:0] wr_data_i,
  input  logic [DATA_W-1:0] wr_mask_i,
  input  logic              lk_req_i,
  input  logic [DATA_W-1:0] lk_key_i,
  output logic              rsp_vld_o,
  output logic              rsp_hit_o,
  output logic [ADDR_W-1:0] rsp_addr_o,
  output logic              rsp_multi_o,
  output logic [ADDR_W:0]   occ_o,
  output logic              full_o,
  output logic              empty_o
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W:0]  OCC_ONE   = (ADDR_W+1)'(1);
  localparam logic [ADDR_W:0]  OCC_FULL  = (ADDR_W+1)'(DEPTH);
  localparam logic [DEPTH-1:0] MATCH_ONE = DEPTH'(1);

  logic [DATA_W-1:0] r_key [DEPTH];
  logic [DATA_W-1:0] w_care [DEPTH];
  logic [DEPTH-1:0]  r_valid;
  logic [ADDR_W:0]   r_occ;

  logic              r_s0Vld;
  logic [DATA_W-1:0] r_s0Key;
  logic [DEPTH-1:0]  w_match;
  logic              r_s1Vld;
  logic [DEPTH-1:0]  r_s1Match;

  logic [ADDR_W-1:0] w_encAddr;
  logic              w_encHit;
  logic              w_encMulti;

  logic              r_rspVld;
  logic              r_rspHit;
  logic [ADDR_W-1:0] r_rspAddr;
  logic              r_rspMulti;

  // Key storage. It has no reset; the valid bits alone decide whether an
  // entry takes part in matching. Writes are ignored while reset is held.
  always_ff @(posedge clk) begin
    if (rst_n && wr_en_i && wr_vld_i) begin
      r_key[wr_addr_i] <= wr_data_i;
    end
  end

  // The care mask exists only in ternary builds. An exact-match build treats
  // every bit as cared about, so the same compare logic serves both.
  generate
    if (TERNARY != 0) begin : g_ternary
      logic [DATA_W-1:0] r_mask [DEPTH];

      always_ff @(posedge clk) begin
        if (rst_n && wr_en_i && wr_vld_i) begin
          r_mask[wr_addr_i] <= wr_mask_i;
        end
      end

      always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
          w_care[i] = r_mask[i];
        end
      end
    end else begin : g_exact
      logic w_unused_mask;
      assign w_unused_mask = ^wr_mask_i;

      always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
          w_care[i] = '1;
        end
      end
    end
  endgenerate

  // Valid bits and occupancy move together. The count changes only when a
  // write actually flips a valid bit, so it can never leave 0..DEPTH.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_valid <= '0;
      r_occ   <= '0;
    end else if (wr_en_i) begin
      r_valid[wr_addr_i] <= wr_vld_i;
      if (wr_vld_i && !r_valid[wr_addr_i]) begin
        r_occ <= r_occ + OCC_ONE;
      end else if (!wr_vld_i && r_valid[wr_addr_i]) begin
        r_occ <= r_occ - OCC_ONE;
      end
    end
  end

  // Request capture. The key register needs no reset because its valid flag
  // is cleared by reset.
  always_ff @(posedge clk) begin
    if (lk_req_i) begin
      r_s0Key <= lk_key_i;
    end
  end

  // Stage 1 compares the captured key against the table as it stands after
  // the capture edge. A write on that same edge is therefore visible, and a
  // write on the following edge is not.
  always_comb begin
    w_match = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_match[i] = r_valid[i] && (((r_key[i] ^ r_s0Key) & w_care[i]) == '0);
    end
  end

  // Pipeline valid flags and the registered match vector. Reset flushes both
  // stages, so requests in flight never produce a response.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_s0Vld   <= 1'b0;
      r_s1Vld   <= 1'b0;
      r_s1Match <= '0;
    end else begin
      r_s0Vld   <= lk_req_i;
      r_s1Vld   <= r_s0Vld;
      r_s1Match <= r_s0Vld ? w_match : '0;
    end
  end

  // Priority encoder: scanning downward leaves the lowest set index in
  // w_encAddr. Clearing the lowest set bit and testing for anything left
  // detects a multi-hit without a full population count.
  always_comb begin
    w_encAddr = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (r_s1Match[i]) begin
        w_encAddr = ADDR_W'(i);
      end
    end
  end

  assign w_encHit   = |r_s1Match;
  assign w_encMulti = |(r_s1Match & (r_s1Match - MATCH_ONE));

  // Result registers. Every result field is forced to zero whenever there is
  // no valid response.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rspVld   <= 1'b0;
      r_rspHit   <= 1'b0;
      r_rspAddr  <= '0;
      r_rspMulti <= 1'b0;
    end else begin
      r_rspVld   <= r_s1Vld;
      r_rspHit   <= r_s1Vld && w_encHit;
      r_rspAddr  <= r_s1Vld ? w_encAddr : '0;
      r_rspMulti <= r_s1Vld && w_encMulti;
    end
  end

  assign rsp_vld_o   = r_rspVld;
  assign rsp_hit_o   = r_rspHit;
  assign rsp_addr_o  = r_rspAddr;
  assign rsp_multi_o = r_rspMulti;
  assign occ_o       = r_occ;
  assign full_o      = (r_occ == OCC_FULL);
  assign empty_o     = (r_occ == '0);

endmodule

// File: tb/tb_pqsdn_cam_pipe.sv
// ---------------------------------------------------------------------------
// TbPqsdnCamPipe -- self-checking bench for pqsdn_cam_pipe.
//
// Two instances share one stimulus stream: one exact-match build and one
// ternary build. A behavioural table model, one per instance, predicts each
// response by scanning plain arrays. A negedge compare process checks every
// output against the model on every cycle. Directed scenarios additionally
// pin the model with hand-computed literal expectations, and a randomized
// phase (with occasional resets) runs last.
// ---------------------------------------------------------------------------
module tb_pqsdn_cam_pipe;

  localparam int DATA_W = 64;
  localparam int ADDR_W = 6;
  localparam int DEPTH  = 64;
  localparam logic [DATA_W-1:0] ALL_ONES = '1;

  logic              clk;
  logic              rst_n;
  logic              wrEn;
  logic              wrVld;
  logic [ADDR_W-1:0] wrAddr;
  logic [DATA_W-1:0] wrData;
  logic [DATA_W-1:0] wrMask;
  logic              lkReq;
  logic [DATA_W-1:0] lkKey;

  logic              rspVld0, rspHit0, rspMulti0, full0, empty0;
  logic [ADDR_W-1:0] rspAddr0;
  logic [ADDR_W:0]   occ0;
  logic              rspVld1, rspHit1, rspMulti1, full1, empty1;
  logic [ADDR_W-1:0] rspAddr1;
  logic [ADDR_W:0]   occ1;

  int assertCount = 0;
  int failCount   = 0;

  pqsdn_cam_pipe #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .TERNARY(0)) dutExact (
    .clk(clk), .rst_n(rst_n), .wr_en_i(wrEn), .wr_vld_i(wrVld),
    .wr_addr_i(wrAddr), .wr_data_i(wrData), .wr_mask_i(wrMask),
    .lk_req_i(lkReq), .lk_key_i(lkKey),
    .rsp_vld_o(rspVld0), .rsp_hit_o(rspHit0), .rsp_addr_o(rspAddr0),
    .rsp_multi_o(rspMulti0), .occ_o(occ0), .full_o(full0), .empty_o(empty0)
  );

  pqsdn_cam_pipe #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .TERNARY(1)) dutTern (
    .clk(clk), .rst_n(rst_n), .wr_en_i(wrEn), .wr_vld_i(wrVld),
    .wr_addr_i(wrAddr), .wr_data_i(wrData), .wr_mask_i(wrMask),
    .lk_req_i(lkReq), .lk_key_i(lkKey),
    .rsp_vld_o(rspVld1), .rsp_hit_o(rspHit1), .rsp_addr_o(rspAddr1),
    .rsp_multi_o(rspMulti1), .occ_o(occ1), .full_o(full1), .empty_o(empty1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  typedef struct packed {
    logic              vld;
    logic              hit;
    logic [ADDR_W-1:0] addr;
    logic              multi;
  } rsp_t;

  logic [DATA_W-1:0] mKey  [2][DEPTH];
  logic [DATA_W-1:0] mMask [2][DEPTH];
  bit                mValid[2][DEPTH];
  rsp_t              d1[2], d2[2], expOut[2];
  bit                modelReady = 1'b0;

  // Scans the model table in index order and reports the first match and
  // whether more than one entry matched.
  function automatic rsp_t lookupModel(input int inst, input logic [DATA_W-1:0] k);
    rsp_t r;
    int n;
    logic [DATA_W-1:0] care;
    r = '0;
    r.vld = 1'b1;
    n = 0;
    for (int i = 0; i < DEPTH; i++) begin
      care = (inst == 1) ? mMask[inst][i] : ALL_ONES;
      if (mValid[inst][i] && (((mKey[inst][i] ^ k) & care) == '0)) begin
        if (n == 0) r.addr = ADDR_W'(i);
        n++;
      end
    end
    r.hit   = (n > 0);
    r.multi = (n > 1);
    return r;
  endfunction

  function automatic int occModel(input int inst);
    int n = 0;
    for (int i = 0; i < DEPTH; i++) if (mValid[inst][i]) n++;
    return n;
  endfunction

  // Advances the model once per rising edge. A request sampled at an edge
  // sees the write from that same edge and becomes visible two edges later.
  initial begin
    forever begin
      @(posedge clk);
      for (int inst = 0; inst < 2; inst++) begin
        if (!rst_n) begin
          for (int i = 0; i < DEPTH; i++) mValid[inst][i] = 1'b0;
          d1[inst] = '0;
          d2[inst] = '0;
          expOut[inst] = '0;
        end else begin
          expOut[inst] = d2[inst];
          d2[inst] = d1[inst];
          if (wrEn) begin
            mValid[inst][wrAddr] = wrVld;
            if (wrVld) begin
              mKey[inst][wrAddr]  = wrData;
              mMask[inst][wrAddr] = wrMask;
            end
          end
          d1[inst] = lkReq ? lookupModel(inst, lkKey) : '0;
        end
      end
      if (!rst_n) modelReady = 1'b1;
    end
  end

  // ---------------- checking helpers ----------------
  task automatic checkOutput(input string name, input int inst,
                             input logic [DATA_W-1:0] actual,
                             input logic [DATA_W-1:0] expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s dut%0d actual=0x%0h required=0x%0h t=%0t",
               name, inst, actual, expected, $time);
    end
  endtask

  task automatic getActual(input int inst, output logic vld, output logic hit,
                           output logic [ADDR_W-1:0] addr, output logic multi,
                           output logic [ADDR_W:0] occ, output logic full,
                           output logic empty);
    if (inst == 0) begin
      vld = rspVld0; hit = rspHit0; addr = rspAddr0; multi = rspMulti0;
      occ = occ0; full = full0; empty = empty0;
    end else begin
      vld = rspVld1; hit = rspHit1; addr = rspAddr1; multi = rspMulti1;
      occ = occ1; full = full1; empty = empty1;
    end
  endtask

  // Continuous comparison against the model on every falling edge.
  always @(negedge clk) begin
    if (modelReady) begin
      for (int inst = 0; inst < 2; inst++) begin
        logic vld, hit, multi, full, empty;
        logic [ADDR_W-1:0] addr;
        logic [ADDR_W:0] occ;
        int expOcc;
        getActual(inst, vld, hit, addr, multi, occ, full, empty);
        expOcc = occModel(inst);
        checkOutput("modelRspVld", inst, DATA_W'(vld), DATA_W'(expOut[inst].vld));
        checkOutput("modelRspHit", inst, DATA_W'(hit), DATA_W'(expOut[inst].hit));
        checkOutput("modelRspAddr", inst, DATA_W'(addr), DATA_W'(expOut[inst].addr));
        checkOutput("modelRspMulti", inst, DATA_W'(multi), DATA_W'(expOut[inst].multi));
        checkOutput("modelOcc", inst, DATA_W'(occ), DATA_W'(expOcc));
        checkOutput("modelFull", inst, DATA_W'(full), DATA_W'(expOcc == DEPTH));
        checkOutput("modelEmpty", inst, DATA_W'(empty), DATA_W'(expOcc == 0));
      end
    end
  end

  task automatic checkRsp(input string name, input int inst, input bit vldE,
                          input bit hitE, input int addrE, input bit multiE);
    logic vld, hit, multi, full, empty;
    logic [ADDR_W-1:0] addr;
    logic [ADDR_W:0] occ;
    getActual(inst, vld, hit, addr, multi, occ, full, empty);
    checkOutput({name, "_vld"}, inst, DATA_W'(vld), DATA_W'(vldE));
    checkOutput({name, "_hit"}, inst, DATA_W'(hit), DATA_W'(hitE));
    checkOutput({name, "_addr"}, inst, DATA_W'(addr), DATA_W'(addrE));
    checkOutput({name, "_multi"}, inst, DATA_W'(multi), DATA_W'(multiE));
  endtask

  task automatic checkOcc(input string name, input int inst, input int occE,
                          input bit fullE, input bit emptyE);
    logic vld, hit, multi, full, empty;
    logic [ADDR_W-1:0] addr;
    logic [ADDR_W:0] occ;
    getActual(inst, vld, hit, addr, multi, occ, full, empty);
    checkOutput({name, "_occ"}, inst, DATA_W'(occ), DATA_W'(occE));
    checkOutput({name, "_full"}, inst, DATA_W'(full), DATA_W'(fullE));
    checkOutput({name, "_empty"}, inst, DATA_W'(empty), DATA_W'(emptyE));
  endtask

  // ---------------- stimulus helpers ----------------
  // Drives one cycle of inputs, waits for the edge, then returns #1 later
  // with the inputs back at idle.
  task automatic applyStimulus(input bit we, input bit wv, input int addr,
                               input logic [DATA_W-1:0] data,
                               input logic [DATA_W-1:0] mask,
                               input bit lr, input logic [DATA_W-1:0] key);
    wrEn   = we;
    wrVld  = wv;
    wrAddr = ADDR_W'(addr);
    wrData = data;
    wrMask = mask;
    lkReq  = lr;
    lkKey  = key;
    @(posedge clk);
    #1;
    wrEn  = 1'b0;
    lkReq = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) applyStimulus(0, 0, 0, '0, ALL_ONES, 0, '0);
  endtask

  task automatic install(input int addr, input logic [DATA_W-1:0] data,
                         input logic [DATA_W-1:0] mask);
    applyStimulus(1, 1, addr, data, mask, 0, '0);
  endtask

  task automatic invalidate(input int addr);
    applyStimulus(1, 0, addr, '0, ALL_ONES, 0, '0);
  endtask

  task automatic doReset();
    rst_n = 1'b0;
    idle(2);
    rst_n = 1'b1;
  endtask

  // Issues one lookup and checks the response two edges later on the
  // instances in the range lo..hi.
  task automatic lookupAndCheck(input string name, input logic [DATA_W-1:0] key,
                                input int lo, input int hi, input bit hitE,
                                input int addrE, input bit multiE);
    applyStimulus(0, 0, 0, '0, ALL_ONES, 1, key);
    idle(2);
    for (int inst = lo; inst <= hi; inst++) checkRsp(name, inst, 1, hitE, addrE, multiE);
  endtask

  function automatic logic [DATA_W-1:0] randKey();
    logic [DATA_W-1:0] k;
    k = DATA_W'($urandom_range(0, 7));
    if ($urandom_range(0, 15) == 0) k[DATA_W-1] = 1'b1;
    return k;
  endfunction

  function automatic logic [DATA_W-1:0] randMask();
    logic [DATA_W-1:0] m;
    m = ALL_ONES;
    m[2:0] = 3'($urandom_range(0, 7));
    if ($urandom_range(0, 7) == 0) m[DATA_W-1] = 1'b0;
    return m;
  endfunction

  // ---------------- main sequence ----------------
  initial begin
    rst_n  = 1'b0;
    wrEn   = 1'b0;
    wrVld  = 1'b0;
    wrAddr = '0;
    wrData = '0;
    wrMask = ALL_ONES;
    lkReq  = 1'b0;
    lkKey  = '0;

    // Reset state.
    doReset();
    for (int inst = 0; inst < 2; inst++) begin
      checkRsp("resetRsp", inst, 0, 0, 0, 0);
      checkOcc("resetOcc", inst, 0, 0, 1);
    end

    // Single entry hit.
    install(5, 64'hA5, ALL_ONES);
    lookupAndCheck("singleHit", 64'hA5, 0, 1, 1, 5, 0);
    for (int inst = 0; inst < 2; inst++) checkOcc("singleOcc", inst, 1, 0, 0);

    // Duplicate keys: lowest index wins, then the survivor after invalidation.
    doReset();
    install(9, 64'h11, ALL_ONES);
    install(3, 64'h11, ALL_ONES);
    lookupAndCheck("dupHit", 64'h11, 0, 1, 1, 3, 1);
    invalidate(3);
    lookupAndCheck("dupAfterInval", 64'h11, 0, 1, 1, 9, 0);
    for (int inst = 0; inst < 2; inst++) checkOcc("dupOcc", inst, 1, 0, 0);

    // Fill the table, then overwrite and double-invalidate one entry.
    doReset();
    for (int i = 0; i < DEPTH; i++) install(i, 64'h1000 + 64'(i), ALL_ONES);
    for (int inst = 0; inst < 2; inst++) checkOcc("fillOcc", inst, 64, 1, 0);
    install(0, 64'h5555, ALL_ONES);
    for (int inst = 0; inst < 2; inst++) checkOcc("overwriteOcc", inst, 64, 1, 0);
    invalidate(0);
    invalidate(0);
    for (int inst = 0; inst < 2; inst++) checkOcc("doubleInvalOcc", inst, 63, 0, 0);
    lookupAndCheck("fullLookup", 64'h103F, 0, 1, 1, 63, 0);

    // Write/lookup ordering: same-edge write visible, next-edge write not.
    doReset();
    applyStimulus(1, 1, 2, 64'h77, ALL_ONES, 1, 64'h77);
    idle(2);
    for (int inst = 0; inst < 2; inst++) checkRsp("sameEdgeWrite", inst, 1, 1, 2, 0);
    applyStimulus(0, 0, 0, '0, ALL_ONES, 1, 64'h88);
    install(6, 64'h88, ALL_ONES);
    idle(1);
    for (int inst = 0; inst < 2; inst++) checkRsp("lateWrite", inst, 1, 0, 0, 0);

    // Ternary low-nibble don't-care; the exact build ignores the mask.
    doReset();
    install(4, 64'hF0, 64'hF0);
    lookupAndCheck("ternF3", 64'hF3, 1, 1, 1, 4, 0);
    lookupAndCheck("ternFF", 64'hFF, 1, 1, 1, 4, 0);
    lookupAndCheck("ternE0", 64'hE0, 1, 1, 0, 0, 0);
    lookupAndCheck("exactF3", 64'hF3, 0, 0, 0, 0, 0);
    lookupAndCheck("exactF0", 64'hF0, 0, 0, 1, 4, 0);

    // Back-to-back lookups with a one-cycle reset in the middle.
    doReset();
    install(7, 64'h42, ALL_ONES);
    for (int k = 0; k < 8; k++) begin
      rst_n = (k != 4);
      applyStimulus(1, 1, 8, 64'h42, ALL_ONES, 1, 64'h42);
      for (int inst = 0; inst < 2; inst++) begin
        if (k == 2 || k == 3) checkRsp("streamPre", inst, 1, 1, 7, 1);
        if (k == 4) begin
          checkRsp("streamReset", inst, 0, 0, 0, 0);
          checkOcc("streamReset", inst, 0, 0, 1);
        end
        if (k == 5 || k == 6) checkRsp("streamFlushed", inst, 0, 0, 0, 0);
        if (k == 7) checkRsp("streamAfter", inst, 1, 1, 8, 0);
      end
    end
    rst_n = 1'b1;
    idle(3);

    // Randomized traffic with occasional resets.
    doReset();
    for (int c = 0; c < 3000; c++) begin
      rst_n = ($urandom_range(0, 299) != 0);
      applyStimulus($urandom_range(0, 1) == 1, $urandom_range(0, 3) != 0,
                    $urandom_range(0, DEPTH - 1), randKey(), randMask(),
                    $urandom_range(0, 3) != 0, randKey());
    end
    rst_n = 1'b1;
    idle(4);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule

// File: doc/pqsdn_cam_pipe.md
PQSDN_CAM_PIPE -- requirements
Module: pqsdn_cam_pipe

Interface
REQ-001 SHALL have parameter DATA_W, default 64, key/entry width in bits.
REQ-002 SHALL have parameter ADDR_W, default 6, entry index width; depth = 2**ADDR_W.
REQ-003 SHALL have parameter TERNARY, default 0; 1 = per-entry care mask stored, 0 = exact match and mask ignored.
REQ-004 SHALL have port clk  input  1  clock; all state updates on rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-006 SHALL have port wr_en_i  input  1  write-port strobe.
REQ-007 SHALL have port wr_vld_i  input  1  1 = install entry, 0 = invalidate entry.
REQ-008 SHALL have port wr_addr_i  input  ADDR_W  target entry index.
REQ-009 SHALL have port wr_data_i  input  DATA_W  entry key.
REQ-010 SHALL have port wr_mask_i  input  DATA_W  care mask (1 = bit compared); used only when TERNARY=1.
REQ-011 SHALL have port lk_req_i  input  1  lookup request, one per cycle, no backpressure.
REQ-012 SHALL have port lk_key_i  input  DATA_W  lookup key.
REQ-013 SHALL have port rsp_vld_o  output  1  result valid, one-cycle pulse per request.
REQ-014 SHALL have port rsp_hit_o  output  1  at least one valid entry matched.
REQ-015 SHALL have port rsp_addr_o  output  ADDR_W  lowest matching index; 0 on miss.
REQ-016 SHALL have port rsp_multi_o  output  1  two or more valid entries matched.
REQ-017 SHALL have port occ_o  output  ADDR_W+1  number of valid entries.
REQ-018 SHALL have ports full_o / empty_o  output  1 each  occ_o == 2**ADDR_W / occ_o == 0.

Function
REQ-019 SHALL store per entry: key (DATA_W), valid bit, and mask (DATA_W) only when TERNARY=1.
REQ-020 SHALL, on edge with wr_en_i=1, wr_vld_i=1: write key/mask at wr_addr_i, set valid.
REQ-021 SHALL, on edge with wr_en_i=1, wr_vld_i=0: clear valid at wr_addr_i; key/mask don't-care.
REQ-022 SHALL update occ_o same edge: +1 install to invalid entry; -1 invalidate of valid entry; unchanged for overwrite of valid entry or invalidate of invalid entry.
REQ-023 SHALL never wrap occ_o; range 0..2**ADDR_W by construction.
REQ-024 SHALL match entry i iff valid[i] and ((key[i] XNOR lookup key) OR ~care[i]) is all ones; care = all ones when TERNARY=0.
REQ-025 SHALL pipeline lookup in 2 stages: edge N samples lk_req_i/lk_key_i; edge N+1 registers match vector; edge N+2 registers encoded result; rsp_vld_o high for the cycle after edge N+2.
REQ-026 SHALL sustain back-to-back lookups, one result per cycle, in request order.
REQ-027 SHALL compare in stage 1 against table contents after edge N; a write at edge N is visible to the lookup sampled at edge N; a write at edge N+1 is not.
REQ-028 SHALL encode lowest index among matches (priority encoder, index 0 highest priority).
REQ-029 SHALL drive rsp_hit_o=0, rsp_addr_o=0, rsp_multi_o=0 on miss.
REQ-030 SHALL hold rsp_hit_o/rsp_addr_o/rsp_multi_o at 0 whenever rsp_vld_o=0.
REQ-031 SHALL derive full_o/empty_o combinationally from registered occ_o.

Reset
REQ-032 SHALL, while rst_n=0 at an edge: clear all valid bits, occ_o=0, clear both pipeline valid flags, rsp_vld_o=0, rsp_hit_o=0, rsp_addr_o=0, rsp_multi_o=0; empty_o=1, full_o=0.
REQ-033 SHALL discard in-flight lookups at reset; no rsp_vld_o pulse for requests sampled before or during reset.
REQ-034 SHALL ignore wr_en_i and lk_req_i while rst_n=0; key/mask storage need not be reset.

Verification
REQ-035 SHALL cover: reset, install key 0xA5 at index 5, lookup 0xA5 at edge N -> rsp_vld_o after edge N+2, hit=1, addr=5, multi=0, occ_o=1.
REQ-036 SHALL cover: install 0x11 at indices 9 and 3, lookup 0x11 -> hit=1, addr=3, multi=1; invalidate 3, lookup -> addr=9, multi=0, occ_o=1.
REQ-037 SHALL cover: fill all 64 entries with distinct keys -> full_o=1, occ_o=64; overwrite index 0 -> occ_o stays 64; invalidate index 0 twice -> occ_o=63 after both.
REQ-038 SHALL cover: write 0x77 at index 2 same edge as lookup 0x77 -> hit, addr=2; lookup 0x88 at edge N with write of 0x88 at edge N+1 -> miss.
REQ-039 SHALL cover: TERNARY=1, entry 4 key 0xF0, mask 0xF0 (low nibble don't-care); lookups 0xF3, 0xFF hit addr=4; 0xE0 misses.
REQ-040 SHALL cover: 8 back-to-back lookups then rst_n low for 1 cycle mid-stream -> no rsp_vld_o for flushed requests, occ_o=0, empty_o=1.
